// File: rtl/cam_pkg.sv
// cam_pkg: shared frame geometry, controller state encoding and pixel format conversion
package cam_pkg;
    localparam int WIDTH_DEF = 176;
    localparam int HEIGHT_DEF = 144;
    localparam int ADDR_W_DEF = 15;
    typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_FRAME, CAPTURE} cam_state_e;
    function automatic logic [7:0] rgb444_to_332(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {r[3:1], g[3:1], b[3:2]};
    endfunction
endpackage

// File: rtl/cam_byte_assembler.sv
// cam_byte_assembler: pairs 0000RRRR / GGGGBBBB camera bytes into RGB332 pixels while enabled
module cam_byte_assembler
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pix_valid,
    output logic [7:0] pix
);
    logic       phase;
    logic [3:0] r;
    // phase drops to 0 whenever href is low so an odd byte count cannot skew the next line
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase <= 1'b0;
            r     <= '0;
        end else begin
            phase <= en & href & ~phase;
            if (en && href && !phase) r <= data[3:0];
        end
    assign pix_valid = en & href & phase;
    assign pix       = rgb444_to_332(r, data[7:4], data[3:0]);
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: arms on start, syncs to the next frame and turns the camera byte stream
// into clipped, linearly addressed RGB332 frame-buffer writes
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int HEIGHT     = HEIGHT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    input  logic              start,
    output logic              busy,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              done,
    output logic              short_frame
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    cam_state_e        state, state_n;
    logic              vs_d, href_d, vs_rise, vs_fall, href_fall;
    logic              cap, pix_valid, x_ok, y_ok;
    logic [7:0]        pix;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    assign vs_rise   = vsync & ~vs_d;
    assign vs_fall   = ~vsync & vs_d;
    assign href_fall = ~href & href_d;
    assign cap       = state == CAPTURE;
    assign x_ok      = x < XW'(WIDTH);
    assign y_ok      = y < YW'(HEIGHT);
    // done keeps busy high through the completion cycle so busy drops one cycle later
    assign busy      = (state != IDLE) | done;
    cam_byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (cap),
        .href      (href),
        .data      (data),
        .pix_valid (pix_valid),
        .pix       (pix)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = start   ? WAIT_VS    : IDLE;
            WAIT_VS:    state_n = vs_rise ? WAIT_FRAME : WAIT_VS;
            WAIT_FRAME: state_n = vs_fall ? CAPTURE    : WAIT_FRAME;
            CAPTURE:    state_n = vs_rise ? (CONTINUOUS ? WAIT_FRAME : IDLE) : CAPTURE;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vs_d        <= 1'b0;
            href_d      <= 1'b0;
            wen         <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            done        <= 1'b0;
            short_frame <= 1'b0;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
        end else begin
            vs_d   <= vsync;
            href_d <= href;
            wen    <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE && start) short_frame <= 1'b0;
            if (state == WAIT_FRAME && vs_fall) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end
            if (cap) begin
                if (pix_valid && x_ok && y_ok) begin
                    wen   <= 1'b1;
                    waddr <= addr;
                    wdata <= pix;
                    addr  <= addr + 1'b1;
                    x     <= x + 1'b1;
                end
                // a truncated line skips the unwritten tail so the next line starts on its row
                if (href_fall) begin
                    if (x_ok && y_ok) begin
                        short_frame <= 1'b1;
                        addr        <= ADDR_W'((int'(y) + 1) * WIDTH);
                    end
                    if (y_ok) y <= y + 1'b1;
                    x <= '0;
                end
                if (vs_rise) begin
                    done <= 1'b1;
                    if (y_ok) short_frame <= 1'b1;
                end
            end
        end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Sequences capture of one camera frame from the OV7670-style pixel stream (VSYNC/HREF/DATA, RGB444 as two bytes per pixel) into the 176x144 frame buffer. It arms on a START request, synchronises to the next frame boundary, and assembles byte pairs into RGB332 pixels. It generates linear write addresses with clipping, then reports DONE or SHORT_FRAME. It sits between the camera/simulator outputs and the frame-buffer write port, in the same CLK domain as the pixel stream.

Parameters:
WIDTH, 176, pixels per line written to memory; later pixels in a line are dropped.
HEIGHT, 144, lines per frame written to memory; later lines are dropped.
ADDR_W, 15, write address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
CONTINUOUS, 0, 1 = re-arm automatically after each frame without a new START.

Ports:
CLK  input  1  pixel clock; all logic on posedge; stream inputs change on negedge.
RST_N  input  1  asynchronous active-low reset.
VSYNC  input  1  frame sync, high between frames.
HREF  input  1  line valid, high while pixel bytes are presented.
DATA  input  8  pixel byte; first byte 0000RRRR, second byte GGGGBBBB.
START  input  1  single-cycle capture request; ignored unless IDLE.
BUSY  output  1  high in every state except IDLE.
WEN  output  1  frame-buffer write strobe, one cycle per stored pixel.
WADDR  output  ADDR_W  write address = line*WIDTH + pixel.
WDATA  output  8  RGB332 pixel {R[3:1],G[3:1],B[3:2]}.
DONE  output  1  one-cycle pulse on frame completion.
SHORT_FRAME  output  1  sticky flag: last frame ended with fewer than HEIGHT lines or fewer than WIDTH pixels in any stored line; cleared by START.

Behaviour:
- Reset (async, RST_N low): state IDLE; BUSY=0, WEN=0, WADDR=0, WDATA=0, DONE=0, SHORT_FRAME=0; all counters and the byte phase are 0; registered vs_d/href_d are 0. Reset mid-capture abandons the frame; no further WEN until a new START.
- Edge detect: vs_rise = VSYNC & ~vs_d; vs_fall = ~VSYNC & vs_d; href_fall = ~HREF & href_d; vs_d and href_d are registered each posedge.
- FSM:
  - IDLE: on START go to WAIT_VS and clear SHORT_FRAME.
  - WAIT_VS: on vs_rise go to WAIT_FRAME. A frame already in progress when START arrives is never captured partially.
  - WAIT_FRAME: on vs_fall go to CAPTURE and clear the x, y, address and phase counters.
  - CAPTURE: on vs_rise, pulse DONE for one cycle. If y<HEIGHT, set SHORT_FRAME. Then go to IDLE, or to WAIT_FRAME when CONTINUOUS=1, since that edge already starts the next frame.
- Byte assembly, CAPTURE only:
  - While HREF=1, phase toggles every cycle.
  - phase=0: latch DATA[3:0] as R.
  - phase=1: form the pixel from the latched R and DATA.
  - When HREF=0, phase is forced to 0, so an odd byte count never mis-pairs the next line.
- Write: on a phase=1 cycle with x<WIDTH and y<HEIGHT, the next posedge drives WEN=1, WADDR=addr, and WDATA. The latency is 1 cycle from sampling the second byte. addr and x then increment. Otherwise WEN=0, and WADDR/WDATA hold their last values.
- Line end, on href_fall in CAPTURE:
  - If x<WIDTH and y<HEIGHT, set SHORT_FRAME and advance addr to the start of the next line (y+1)*WIDTH.
  - If y<HEIGHT, increment y.
  - x always resets to 0.
  - y saturates at HEIGHT, so extra lines produce no writes.
- Address range: the maximum WADDR is WIDTH*HEIGHT-1 (25343). The address never wraps within a frame.
- Simultaneous events: vs_rise and a pending write in the same cycle complete the write first, and DONE is asserted in that same cycle. START while BUSY is ignored.

Decomposition:
- Shared package cam_pkg: the WIDTH/HEIGHT/ADDR_W defaults, FSM state encoding (IDLE, WAIT_VS, WAIT_FRAME, CAPTURE), and an RGB444 to RGB332 conversion function.
- One natural sub-module, cam_byte_assembler: phase toggle, R latch, and pixel-valid generation from HREF/DATA. The controller keeps the FSM, counters and address logic.

Test Plan:
- Colour-bar stream driven by the simulator, START at cycle 10 (mid-frame): no WEN until after the second VSYNC pulse. The first frame's writes must show:
  - WADDR 0 = 0xE0 (red 0x0F,0x00).
  - WADDR 20 = 0x1C (green 0x00,0xF0).
  - WADDR 40 = 0x03 (blue 0x00,0x0F).
  - WADDR 140 = 0x00.
  - WADDR 176 = 0xE0.
- Full frame: exactly 25344 WEN pulses; last WADDR 25343; DONE one cycle on the next vs_rise; SHORT_FRAME=0; BUSY falls to 0 the cycle after DONE.
- Short frame of 100 lines, then VSYNC: DONE pulses, SHORT_FRAME=1, 17600 writes, max WADDR 17599. The next START clears SHORT_FRAME.
- Over-long line of 180 pixels and 150 lines: writes stop at x=175 and y=143 with no address overflow. The write count stays 25344.
- RST_N low for 2 cycles mid-line 50, then high: WEN=0 and BUSY=0 immediately with no further writes. A fresh START captures a clean frame starting at WADDR 0.
- CONTINUOUS=1: three consecutive frames give 3 DONE pulses, WADDR restarting at 0 after each vs_fall, and BUSY never dropping.
